// File: rtl/debounce_multi.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_multi
//  Description : Multi-channel pushbutton conditioner. Each channel has a
//                two-flop synchroniser, a debounce counter, a clean level,
//                press/release strobes, and long-press / auto-repeat strobes
//                timed by one shared free-running prescaler.
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_multi #(
  parameter int CHANNELS     = 4,
  parameter int DELAY        = 16,
  parameter bit ACTIVE_LOW   = 1'b1,
  parameter int TICK_W       = 16,
  parameter int HOLD_TICKS   = 24,
  parameter int REPEAT_TICKS = 6
) (
  input  logic                CLK,
  input  logic                nRESET,
  input  logic [CHANNELS-1:0] PB,
  output logic [CHANNELS-1:0] PB_state,
  output logic [CHANNELS-1:0] PB_down,
  output logic [CHANNELS-1:0] PB_up,
  output logic [CHANNELS-1:0] PB_long,
  output logic [CHANNELS-1:0] PB_repeat
);

  localparam logic [7:0] C_HOLD_LAST   = 8'(HOLD_TICKS - 1);
  localparam logic [7:0] C_REPEAT_LAST = 8'(REPEAT_TICKS - 1);

  typedef enum logic [1:0] {
    H_IDLE   = 2'd0,
    H_HOLD   = 2'd1,
    H_REPEAT = 2'd2
  } hold_state_t;

  // After normalisation a 1 always means "pressed", so 0 is the released level.
  logic [CHANNELS-1:0] pressed_raw;
  assign pressed_raw = PB ^ {CHANNELS{ACTIVE_LOW}};

  logic [CHANNELS-1:0] sync0_q, sync0_d;
  logic [CHANNELS-1:0] sync1_q, sync1_d;
  logic [TICK_W-1:0]   presc_q, presc_d;
  logic                tick;

  // Next-state for the synchroniser chain and the shared prescaler.
  always_comb begin
    sync0_d = pressed_raw;
    sync1_d = sync0_q;
    presc_d = presc_q + TICK_W'(1);
  end

  assign tick = &presc_q;

  // Synchroniser and prescaler registers; prescaler ignores button activity.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      sync0_q <= '0;
      sync1_q <= '0;
      presc_q <= '0;
    end else begin
      sync0_q <= sync0_d;
      sync1_q <= sync1_d;
      presc_q <= presc_d;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [DELAY-1:0] cnt_q, cnt_d;
    logic             state_q, state_d;
    logic             idle;
    logic             cnt_max;
    logic             down_stb;
    logic             up_stb;
    hold_state_t      hst_q;
    logic [7:0]       hcnt_q;
    logic             long_q;
    logic             rep_q;

    assign idle     = (state_q == sync1_q[g]);
    assign cnt_max  = &cnt_q;
    assign down_stb = ~idle & cnt_max & ~state_q;
    assign up_stb   = ~idle & cnt_max &  state_q;

    // Count while the synchronised input disagrees with the clean level;
    // the all-ones cycle flips the level and the counter wraps to zero.
    always_comb begin
      cnt_d   = idle ? '0 : cnt_q + DELAY'(1);
      state_d = (~idle & cnt_max) ? ~state_q : state_q;
    end

    // Debounce registers.
    always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
        cnt_q   <= '0;
        state_q <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        state_q <= state_d;
      end
    end

    // Hold / repeat FSM. The release edge (up_stb) is treated like a released
    // level so that a registered strobe can never appear once PB_state is 0.
    always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
        hst_q  <= H_IDLE;
        hcnt_q <= '0;
        long_q <= 1'b0;
        rep_q  <= 1'b0;
      end else begin
        long_q <= 1'b0;
        rep_q  <= 1'b0;
        if (!state_q || up_stb) begin
          hst_q  <= H_IDLE;
          hcnt_q <= '0;
        end else begin
          case (hst_q)
            H_IDLE: begin
              hst_q  <= H_HOLD;
              hcnt_q <= '0;
            end
            H_HOLD: begin
              if (tick) begin
                if (hcnt_q == C_HOLD_LAST) begin
                  long_q <= 1'b1;
                  hcnt_q <= '0;
                  hst_q  <= H_REPEAT;
                end else begin
                  hcnt_q <= hcnt_q + 8'd1;
                end
              end
            end
            H_REPEAT: begin
              if (tick) begin
                if (hcnt_q == C_REPEAT_LAST) begin
                  rep_q  <= 1'b1;
                  hcnt_q <= '0;
                end else begin
                  hcnt_q <= hcnt_q + 8'd1;
                end
              end
            end
            default: begin
              hst_q  <= H_IDLE;
              hcnt_q <= '0;
            end
          endcase
        end
      end
    end

    assign PB_state[g]  = state_q;
    assign PB_down[g]   = down_stb;
    assign PB_up[g]     = up_stb;
    assign PB_long[g]   = long_q;
    assign PB_repeat[g] = rep_q;
  end

endmodule
`default_nettype wire

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
- Multi-channel pushbutton conditioner; successor to the single-channel debouncer.
- Per channel: two-flop synchroniser, debounce counter, clean level, press/release strobes.
- Adds input polarity selection, long-press detection and auto-repeat strobes, timed by one shared prescaler.
- Sits between board pins and the front-panel/keypad logic of the counter designs.

Parameters:
- CHANNELS, 4, number of independent button inputs (1..32)
- DELAY, 16, debounce counter width; input must be stable for 2^DELAY cycles
- ACTIVE_LOW, 1, 1: pin low = pressed; 0: pin high = pressed
- TICK_W, 16, shared prescaler width; one tick every 2^TICK_W cycles
- HOLD_TICKS, 24, ticks of continuous press before PB_long (1..255)
- REPEAT_TICKS, 6, ticks between PB_repeat strobes after PB_long (1..255)

Ports:
- CLK  in  1  single system clock, all logic on rising edge
- nRESET  in  1  asynchronous, active-low reset
- PB  in  CHANNELS  raw asynchronous button pins
- PB_state  out  CHANNELS  debounced level, 1 = pressed
- PB_down  out  CHANNELS  one-cycle strobe on debounced press
- PB_up  out  CHANNELS  one-cycle strobe on debounced release
- PB_long  out  CHANNELS  one-cycle strobe when press held HOLD_TICKS ticks
- PB_repeat  out  CHANNELS  one-cycle strobes at REPEAT_TICKS intervals after PB_long, while held

Behaviour:
- Reset (nRESET=0, async): all synchroniser flops, counters, prescaler, hold/repeat counters and outputs cleared to 0. Synchroniser reset value is the released level.
- Normalise: pressed_raw = PB ^ {CHANNELS{ACTIVE_LOW}}. Two-stage sync giving sync1, 2-cycle latency.
- Debounce, per channel, idle = (state == sync1):
  - idle: cnt <= 0.
  - not idle: cnt <= cnt+1 (wraps to 0 at all-ones). When cnt is all-ones, state <= ~state in the same edge.
  - Any return to idle before all-ones clears cnt. Glitches shorter than 2^DELAY cycles are fully rejected.
- Strobes are combinational from registered state: PB_down = ~idle & cnt_max & ~state; PB_up = ~idle & cnt_max & state. Each is high for exactly the cycle before state changes.
- Latency: pin edge to PB_down = 2 sync cycles + 2^DELAY cycles.
- Prescaler:
  - Free-running TICK_W-bit counter shared by all channels.
  - tick = counter all-ones.
  - Not reset by button activity.
- Hold FSM, per channel, states IDLE, HOLD, REPEAT:
  - IDLE: on state rising, hcnt <= 0, go to HOLD.
  - HOLD: on tick, hcnt++. When hcnt == HOLD_TICKS-1 and tick, assert PB_long that cycle, hcnt <= 0, go to REPEAT.
  - REPEAT: on tick, hcnt++. When hcnt == REPEAT_TICKS-1 and tick, assert PB_repeat that cycle, hcnt <= 0.
  - state==0 in any state: go to IDLE, hcnt <= 0, no strobe that cycle.
  - Hold time is quantised to ticks. Jitter < 1 tick, because the first tick may come early.
  - hcnt is 8 bits.
- PB_long/PB_repeat are registered: they assert the cycle after the qualifying tick.
- Channels are fully independent. Simultaneous events on different channels each produce their own strobes in the same cycle.
- PB_down and PB_up are mutually exclusive per channel. PB_long and PB_repeat never assert while state==0.
- Reset mid-press: all outputs drop immediately. If the pin is still pressed after nRESET rises, a fresh PB_down occurs after 2+2^DELAY cycles.

Test Plan (DELAY=4, TICK_W=3, HOLD_TICKS=3, REPEAT_TICKS=2, CHANNELS=4, ACTIVE_LOW=1):
- Reset with PB=4'hF held -> all outputs 0. No strobes over 100 cycles.
- PB[0] driven low at cycle 10 and held -> PB_down[0] single pulse at cycle 10+2+16 (±1 for sample edge). PB_state[0]=1 the next cycle.
- PB[1] low for 10 cycles, then high, repeated 5 times -> no PB_down[1], PB_state[1] stays 0.
- PB[2] held pressed 200 cycles -> PB_long[2] once, about 24 cycles after PB_state rises (within one tick). Then PB_repeat[2] every 16 cycles. On release, a PB_up[2] pulse and no further repeats.
- PB[0] and PB[3] pressed on the same edge -> PB_down[0] and PB_down[3] in the same cycle. Release of one leaves the other's PB_state at 1.
- nRESET asserted during REPEAT on channel 2 with PB still low -> outputs clear asynchronously. After release, PB_down[2] 18 cycles later and the hold sequence restarts from IDLE.
